// File: rtl/spi_arbiter_pkg.sv
// Shared definitions for the SPI arbiter: requester count, FSM state
// encoding and a one-hot decode helper.
package spi_arbiter_pkg;

  localparam int unsigned N_REQ = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_REQ   = 3'd2,
    S_DRAIN = 3'd3,
    S_HOLD  = 3'd4,
    S_ACK   = 3'd5
  } state_t;

  function automatic logic [N_REQ-1:0] onehot4(input logic [1:0] idx);
    onehot4      = '0;
    onehot4[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/spi_arbiter_rr_arb4.sv
// Combinational round-robin picker: first pending index after 'last',
// wrapping modulo 4; 'last' itself is considered last.
module rr_arb4
  import spi_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] pending,
  input  logic [1:0]       last,
  output logic [1:0]       idx,
  output logic             valid
);

  logic [1:0] cand;

  always_comb begin
    idx   = last;
    valid = 1'b0;
    cand  = last;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = last + 2'(k);
      if (!valid && pending[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Four-requester arbiter in front of a single SPI master: round-robin
// grant, chip-select setup/hold timing and per-requester acknowledge.
module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int unsigned P_WR_DATA_WIDTH = 256,
  parameter int unsigned P_RD_DATA_WIDTH = 256,
  parameter int unsigned P_CS_SETUP      = 4,
  parameter int unsigned P_CS_HOLD       = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [N_REQ-1:0]                 req_wr,
  input  logic [N_REQ-1:0]                 req_rd,
  input  logic [N_REQ*P_WR_DATA_WIDTH-1:0] req_wr_data,
  output logic [N_REQ-1:0]                 req_ack,
  output logic [P_RD_DATA_WIDTH-1:0]       rd_data,
  output logic [1:0]                       grant,
  output logic                             busy,
  output logic [N_REQ-1:0]                 cs_n,
  output logic                             spi_wr_req,
  output logic                             spi_rd_req,
  output logic [P_WR_DATA_WIDTH-1:0]       spi_wr_data,
  input  logic [P_RD_DATA_WIDTH-1:0]       spi_rd_data,
  input  logic                             spi_ack
);

  localparam int unsigned SETUP_CYC  = (P_CS_SETUP == 0) ? 1 : P_CS_SETUP;
  localparam int unsigned HOLD_CYC   = (P_CS_HOLD == 0) ? 1 : P_CS_HOLD;
  localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(HOLD_CYC - 1);

  state_t                       state, state_d;
  logic [1:0]                   last_grant;
  logic                         wr_flag, rd_flag;
  logic [15:0]                  counter;
  logic [1:0]                   arb_idx;
  logic                         arb_valid;
  logic [P_WR_DATA_WIDTH-1:0]   sel_wr_data;
  logic                         req_released;

  rr_arb4 u_rr_arb4 (
    .pending (req_wr | req_rd),
    .last    (last_grant),
    .idx     (arb_idx),
    .valid   (arb_valid)
  );

  always_comb begin
    sel_wr_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_idx == 2'(i)) sel_wr_data = req_wr_data[i*P_WR_DATA_WIDTH +: P_WR_DATA_WIDTH];
    end
  end

  assign req_released = !req_wr[grant] && !req_rd[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  // Outputs are decoded from the registered state so an async reset
  // returns them to idle values within the same cycle.
  always_comb begin
    state_d    = state;
    busy       = 1'b1;
    cs_n       = '1;
    req_ack    = '0;
    spi_wr_req = 1'b0;
    spi_rd_req = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (arb_valid) state_d = S_SETUP;
      end
      S_SETUP: begin
        cs_n = ~onehot4(grant);
        if (counter == SETUP_LAST) state_d = S_REQ;
      end
      S_REQ: begin
        cs_n       = ~onehot4(grant);
        spi_wr_req = wr_flag;
        spi_rd_req = rd_flag;
        if (spi_ack) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        cs_n = ~onehot4(grant);
        if (!spi_ack) state_d = S_HOLD;
      end
      S_HOLD: begin
        cs_n = ~onehot4(grant);
        if (counter == HOLD_LAST) state_d = S_ACK;
      end
      S_ACK: begin
        req_ack = onehot4(grant);
        if (req_released) state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant       <= '0;
      last_grant  <= 2'd3;
      wr_flag     <= 1'b0;
      rd_flag     <= 1'b0;
      counter     <= '0;
      rd_data     <= '0;
      spi_wr_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arb_valid) begin
            grant       <= arb_idx;
            wr_flag     <= req_wr[arb_idx];
            rd_flag     <= req_rd[arb_idx];
            spi_wr_data <= sel_wr_data;
            counter     <= '0;
          end
        end
        S_SETUP, S_HOLD: counter <= counter + 16'd1;
        S_REQ: begin
          if (spi_ack && rd_flag) rd_data <= spi_rd_data;
        end
        S_DRAIN: begin
          if (!spi_ack) counter <= '0;
        end
        S_ACK: begin
          if (req_released) last_grant <= grant;
        end
        default: begin
          grant       <= '0;
          last_grant  <= 2'd3;
          wr_flag     <= 1'b0;
          rd_flag     <= 1'b0;
          counter     <= '0;
          rd_data     <= '0;
          spi_wr_data <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: vector table, scoreboard of expected
// acknowledges, and hand-written sequences for hold, abort and round robin.
module tb_spi_arbiter;
  import spi_arbiter_pkg::*;

  localparam int unsigned W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req_wr = '0;
  logic [3:0]       req_rd = '0;
  logic [4*W-1:0]   req_wr_data = '0;
  logic [3:0]       req_ack;
  logic [W-1:0]     rd_data;
  logic [1:0]       grant;
  logic             busy;
  logic [3:0]       cs_n;
  logic             spi_wr_req, spi_rd_req;
  logic [W-1:0]     spi_wr_data;
  logic [W-1:0]     spi_rd_data;
  logic             spi_ack;

  spi_arbiter #(
    .P_WR_DATA_WIDTH (W),
    .P_RD_DATA_WIDTH (W),
    .P_CS_SETUP      (4),
    .P_CS_HOLD       (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_wr      (req_wr),
    .req_rd      (req_rd),
    .req_wr_data (req_wr_data),
    .req_ack     (req_ack),
    .rd_data     (rd_data),
    .grant       (grant),
    .busy        (busy),
    .cs_n        (cs_n),
    .spi_wr_req  (spi_wr_req),
    .spi_rd_req  (spi_rd_req),
    .spi_wr_data (spi_wr_data),
    .spi_rd_data (spi_rd_data),
    .spi_ack     (spi_ack)
  );

  always #5 clk = ~clk;

  // SPI master model: acks a request after a short delay, releases the ack
  // once both requests have dropped, and records what it was asked to do.
  logic [W-1:0] model_rd = '0;
  logic [1:0]   m_cnt;
  logic         seen_wr, seen_rd;
  logic [W-1:0] seen_data;
  int unsigned  xfer_cnt, wr_high_cnt;

  assign spi_rd_data = spi_ack ? model_rd : 16'h0BAD;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_ack     <= 1'b0;
      m_cnt       <= '0;
      seen_wr     <= 1'b0;
      seen_rd     <= 1'b0;
      seen_data   <= '0;
      xfer_cnt    <= 0;
      wr_high_cnt <= 0;
    end else begin
      if (spi_wr_req) wr_high_cnt <= wr_high_cnt + 1;
      if (!spi_ack && (spi_wr_req || spi_rd_req)) begin
        if (m_cnt == 2'd2) begin
          spi_ack   <= 1'b1;
          m_cnt     <= '0;
          seen_wr   <= spi_wr_req;
          seen_rd   <= spi_rd_req;
          seen_data <= spi_wr_data;
          xfer_cnt  <= xfer_cnt + 1;
        end else begin
          m_cnt <= m_cnt + 2'd1;
        end
      end else if (spi_ack && !spi_wr_req && !spi_rd_req) begin
        spi_ack <= 1'b0;
      end
    end
  end

  typedef struct {
    int unsigned idx;
    logic        wr;
    logic        rd;
    logic [W-1:0] wdata;
    logic [W-1:0] rdata;
  } exp_t;

  typedef struct {
    int unsigned  idx;
    logic         wr;
    logic         rd;
    logic [W-1:0] wdata;
    logic [W-1:0] ret;
    logic [3:0]   cs;
    logic [W-1:0] exp_rd;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[6];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_unexpected_ack", 32'(req_ack), 32'd0);
      return;
    end
    e = sb.pop_front();
    check("ack_onehot", 32'(req_ack), 32'd1 << e.idx);
    check("grant", 32'(grant), e.idx);
    check("rd_data", 32'(rd_data), 32'(e.rdata));
    check("spi_wr_seen", 32'(seen_wr), 32'(e.wr));
    check("spi_rd_seen", 32'(seen_rd), 32'(e.rd));
    if (e.wr) check("spi_wr_data", 32'(seen_data), 32'(e.wdata));
  endtask

  task automatic wait_ack();
    int unsigned n = 0;
    while (req_ack == 4'd0 && n < 200) begin
      tick();
      n++;
    end
    if (req_ack == 4'd0) check("ack_timeout", n, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n, x0, w0;
    logic        ack_any;
    vec_t        t;

    vecs[0] = '{2, 1'b1, 1'b0, 16'h00A5, 16'h1111, 4'b1011, 16'h0000};
    vecs[1] = '{1, 1'b0, 1'b1, 16'h0000, 16'hDEAD, 4'b1101, 16'hDEAD};
    vecs[2] = '{2, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 4'b1011, 16'hBEEF};
    vecs[3] = '{0, 1'b1, 1'b0, 16'h5A5A, 16'h0F0F, 4'b1110, 16'hBEEF};
    vecs[4] = '{3, 1'b0, 1'b1, 16'hFFFF, 16'h0001, 4'b0111, 16'h0001};
    vecs[5] = '{3, 1'b1, 1'b1, 16'h8001, 16'hFFFF, 4'b0111, 16'hFFFF};

    tick();
    tick();
    check("rst_cs_n", 32'(cs_n), 32'hF);
    check("rst_req_ack", 32'(req_ack), 32'd0);
    check("rst_spi_wr_req", 32'(spi_wr_req), 32'd0);
    check("rst_spi_rd_req", 32'(spi_rd_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_spi_wr_data", 32'(spi_wr_data), 32'd0);
    rst = 1'b0;
    tick();

    foreach (vecs[v]) begin
      t = vecs[v];
      model_rd = t.ret;
      x0 = xfer_cnt;
      w0 = wr_high_cnt;
      req_wr_data = {$urandom, $urandom};
      req_wr_data[t.idx*W +: W] = t.wdata;
      req_wr[t.idx] = t.wr;
      req_rd[t.idx] = t.rd;
      sb.push_back('{t.idx, t.wr, t.rd, t.wdata, t.exp_rd});

      n = 0;
      while (!(spi_wr_req || spi_rd_req) && n < 50) begin
        tick();
        n++;
        if (n == 1) req_wr_data[t.idx*W +: W] = ~t.wdata;
      end
      check("setup_latency", n, 32'd5);
      check("cs_n_active", 32'(cs_n), 32'(t.cs));
      check("spi_wr_req", 32'(spi_wr_req), 32'(t.wr));
      check("spi_rd_req", 32'(spi_rd_req), 32'(t.rd));
      if (t.wr) check("spi_wr_data_latched", 32'(spi_wr_data), 32'(t.wdata));

      n = 0;
      while (!spi_ack && n < 50) begin tick(); n++; end
      n = 0;
      while (spi_ack && n < 50) begin tick(); n++; end
      // One cycle in S_DRAIN to see ack low, then P_CS_HOLD cycles in S_HOLD.
      n = 0;
      while (req_ack == 4'd0 && n < 50) begin tick(); n++; end
      check("hold_to_ack", n, 32'd5);
      pop_compare();
      check("cs_release", 32'(cs_n), 32'hF);
      check("xfer_count", xfer_cnt - x0, 32'd1);
      check("wr_req_seen", 32'(wr_high_cnt != w0), 32'(t.wr));

      for (int k = 0; k < 3; k++) begin
        tick();
        check("ack_held", 32'(req_ack), 32'(onehot4(2'(t.idx))));
      end
      req_wr[t.idx] = 1'b0;
      req_rd[t.idx] = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ack", 32'(req_ack), 32'd0);
    end

    // Held request after ack blocks another pending requester.
    req_wr_data[0 +: W] = 16'h0101;
    req_wr_data[W +: W] = 16'h0202;
    req_wr = 4'b0001;
    sb.push_back('{0, 1'b1, 1'b0, 16'h0101, 16'hFFFF});
    wait_ack();
    pop_compare();
    req_wr[1] = 1'b1;
    sb.push_back('{1, 1'b1, 1'b0, 16'h0202, 16'hFFFF});
    for (int k = 0; k < 6; k++) begin
      tick();
      check("hold_ack", 32'(req_ack), 32'h1);
      check("hold_cs_n", 32'(cs_n), 32'hF);
    end
    req_wr[0] = 1'b0;
    tick();
    check("drop_busy", 32'(busy), 32'd0);
    tick();
    check("next_cs_n", 32'(cs_n), 32'b1101);
    wait_ack();
    pop_compare();
    req_wr[1] = 1'b0;
    tick();
    check("drop2_busy", 32'(busy), 32'd0);

    // Reset during S_REQ aborts at once and no ack follows.
    req_wr_data[W +: W] = 16'h7777;
    req_wr = 4'b0010;
    n = 0;
    while (!spi_wr_req && n < 50) begin tick(); n++; end
    check("abort_latency", n, 32'd5);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_cs_n", 32'(cs_n), 32'hF);
    check("abort_spi_wr", 32'(spi_wr_req), 32'd0);
    check("abort_spi_rd", 32'(spi_rd_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rd_data", 32'(rd_data), 32'd0);
    req_wr = '0;
    tick();
    rst = 1'b0;
    ack_any = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      ack_any = ack_any | (|req_ack);
    end
    check("abort_no_ack", 32'(ack_any), 32'd0);

    // All four request from reset: grant order 0,1,2,3,0.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) req_wr_data[i*W +: W] = 16'hA000 + 16'(i);
    req_wr = 4'hF;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++)
      sb.push_back('{k % 4, 1'b1, 1'b0, 16'hA000 + 16'(k % 4), 16'h0000});
    for (int k = 0; k < 5; k++) begin
      wait_ack();
      pop_compare();
      req_wr[k % 4] = 1'b0;
      tick();
      if (k < 4) req_wr[k % 4] = 1'b1;
    end
    req_wr = '0;
    tick();
    tick();
    check("rr_idle", 32'(busy), 32'd0);
    check("sb_empty", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
